// File: rtl/simon_arbiter_if.sv
// -----------------------------------------------------------------------------
// simon_arbiter_if
//   Bundles the request bus, the tagged response channel and the link to the
//   shared simon core that the arbiter sits between.
//
//   Signals (named from the arbiter's point of view in the 'slave' modport):
//     req_valid/req_ready        per-requester valid/accept, NREQ bits each
//     req_plaintext/req_key      flattened per-requester operands
//     resp_valid/resp_ready      response handshake
//     resp_id/resp_data/resp_err owner index, ciphertext, timeout flag
//     core_en/core_plaintext/core_key   drive the simon core inputs
//     core_done/core_ciphertext         simon core outputs
//     busy                       arbiter is not idle
//
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (requesters, response sink and simon core)
// -----------------------------------------------------------------------------
interface simon_arbiter_if #(
    parameter int unsigned N    = 16,
    parameter int unsigned M    = 4,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned BlkW = 2 * N;
    localparam int unsigned KeyW = N * M;
    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BlkW-1:0] req_plaintext;
    logic [NREQ*KeyW-1:0] req_key;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [IdW-1:0]       resp_id;
    logic [BlkW-1:0]      resp_data;
    logic                 resp_err;

    logic                 core_en;
    logic [BlkW-1:0]      core_plaintext;
    logic [KeyW-1:0]      core_key;
    logic                 core_done;
    logic [BlkW-1:0]      core_ciphertext;

    logic                 busy;

    modport slave (
        input  req_valid,
        input  req_plaintext,
        input  req_key,
        input  resp_ready,
        input  core_done,
        input  core_ciphertext,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_data,
        output resp_err,
        output core_en,
        output core_plaintext,
        output core_key,
        output busy
    );

    modport master (
        output req_valid,
        output req_plaintext,
        output req_key,
        output resp_ready,
        output core_done,
        output core_ciphertext,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_data,
        input  resp_err,
        input  core_en,
        input  core_plaintext,
        input  core_key,
        input  busy
    );
endinterface

// File: rtl/simon_arbiter.sv
// -----------------------------------------------------------------------------
// simon_arbiter
//   Round-robin arbiter and sequencer sharing one simon core between NREQ
//   requesters. One request is in flight at a time: the winner's operands are
//   captured into hold registers, the core is started with a single-cycle
//   core_en pulse, and the ciphertext (or a timeout error) is returned on a
//   tagged response channel.
//
//   Ports:
//     i_clk  - clock, all state on posedge
//     i_rst  - synchronous active-high reset, aborts any operation in flight
//     bus    - simon_arbiter_if.slave: request bus, response channel, core link
//
//   Parameters:
//     N, M     - simon word size and key word count
//     NREQ     - number of requesters (2..16)
//     TIMEOUT  - WAIT cycles allowed before aborting with resp_err (1..65535)
// -----------------------------------------------------------------------------
module simon_arbiter #(
    parameter int unsigned N       = 16,
    parameter int unsigned M       = 4,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    simon_arbiter_if.slave bus
);
    localparam int unsigned BlkW = 2 * N;
    localparam int unsigned KeyW = N * M;
    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = 16;

    // Last WAIT cycle index; reaching it without done means the op timed out.
    localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT - 1);
    localparam logic [IdW-1:0]  LastInit = IdW'(NREQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    // State and hold registers
    state_e          r_state;
    logic [IdW-1:0]  r_last_grant;
    logic [IdW-1:0]  r_id;
    logic [BlkW-1:0] r_pt;
    logic [KeyW-1:0] r_key;
    logic [BlkW-1:0] r_data;
    logic            r_err;
    logic [CntW-1:0] r_cnt;

    // Next-state values
    state_e          w_state_next;
    logic [IdW-1:0]  w_last_grant_next;
    logic [IdW-1:0]  w_id_next;
    logic [BlkW-1:0] w_pt_next;
    logic [KeyW-1:0] w_key_next;
    logic [BlkW-1:0] w_data_next;
    logic            w_err_next;
    logic [CntW-1:0] w_cnt_next;

    // Round-robin search
    logic            w_found;
    logic [IdW-1:0]  w_grant;
    logic [IdW-1:0]  w_idx;
    logic [NREQ-1:0] w_req_ready;

    // ------------------------------------------------------------------
    // Grant: first valid requester scanning from last_grant+1, wrapping.
    // The previous winner is visited last, which bounds any wait to NREQ-1
    // operations.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            w_idx = IdW'((int'(r_last_grant) + k) % int'(NREQ));
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == StIdle && w_found) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_id_next         = r_id;
        w_pt_next         = r_pt;
        w_key_next        = r_key;
        w_data_next       = r_data;
        w_err_next        = r_err;
        w_cnt_next        = r_cnt;

        unique case (r_state)
            StIdle: begin
                // req_ready is the one-hot grant, so a found grant is an accept.
                if (w_found) begin
                    w_pt_next         = bus.req_plaintext[int'(w_grant)*BlkW +: BlkW];
                    w_key_next        = bus.req_key[int'(w_grant)*KeyW +: KeyW];
                    w_id_next         = w_grant;
                    w_last_grant_next = w_grant;
                    w_state_next      = StIssue;
                end
            end
            StIssue: begin
                // core_done may still be high from the previous op; ignore it here.
                w_cnt_next   = '0;
                w_state_next = StWait;
            end
            StWait: begin
                if (bus.core_done) begin
                    w_data_next  = bus.core_ciphertext;
                    w_err_next   = 1'b0;
                    w_state_next = StResp;
                end else if (r_cnt == CntLast) begin
                    w_data_next  = '0;
                    w_err_next   = 1'b1;
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StResp: begin
                // No grant in the handshake cycle; IDLE is entered first.
                if (bus.resp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_last_grant <= LastInit;
            r_id         <= '0;
            r_pt         <= '0;
            r_key        <= '0;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_id         <= w_id_next;
            r_pt         <= w_pt_next;
            r_key        <= w_key_next;
            r_data       <= w_data_next;
            r_err        <= w_err_next;
            r_cnt        <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registered state, so resp_valid never
    // depends on resp_ready.
    // ------------------------------------------------------------------
    assign bus.req_ready      = w_req_ready;
    assign bus.core_en        = (r_state == StIssue);
    assign bus.core_plaintext = r_pt;
    assign bus.core_key       = r_key;
    assign bus.resp_valid     = (r_state == StResp);
    assign bus.resp_id        = r_id;
    assign bus.resp_data      = r_data;
    assign bus.resp_err       = r_err;
    assign bus.busy           = (r_state != StIdle);

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_ready_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(bus.req_ready));

    a_resp_hold : assert property (@(posedge i_clk) disable iff (i_rst)
        (bus.resp_valid && !bus.resp_ready) |=>
            (bus.resp_valid && $stable(bus.resp_data) && $stable(bus.resp_id)
             && $stable(bus.resp_err)));

endmodule

// File: tb/tb_simon_arbiter.sv
module tb_simon_arbiter;
    localparam int unsigned N       = 16;
    localparam int unsigned M       = 4;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simon_arbiter_if #(.N(N), .M(M), .NREQ(NREQ)) bus ();

    simon_arbiter #(
        .N       (N),
        .M       (M),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int model_last = NREQ - 1;
    int grants[$];

    // ---------------- Simon32/64 reference ----------------
    function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [31:0] simon32(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k [0:31];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t    = ror16(k[i-1], 3) ^ k[i-3];
            t    = t ^ ror16(t, 1);
            k[i] = ~k[i-4] ^ t ^ 16'(z[61 - ((i - 4) % 62)]) ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // ---------------- Behavioural core stand-in ----------------
    // done stays high until the next en is seen, so back-to-back ops present a
    // stale done during ISSUE.
    int unsigned core_lat  = 5;
    bit          core_hang = 1'b0;
    int unsigned core_cnt  = 0;
    logic [31:0] core_res  = '0;

    always @(posedge clk) begin
        if (rst) begin
            bus.core_done       <= 1'b0;
            bus.core_ciphertext <= '0;
            core_cnt            <= 0;
        end else if (bus.core_en) begin
            bus.core_done <= 1'b0;
            core_cnt      <= core_hang ? 0 : core_lat;
            core_res      <= simon32(bus.core_plaintext, bus.core_key);
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                bus.core_done       <= 1'b1;
                bus.core_ciphertext <= core_res;
            end
        end
    end

    // ---------------- Checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation starting at a negedge in IDLE with req_valid already set.
    task automatic run_op(input int unsigned lat, input bit hang, input int unsigned hold,
                          input string tag, output logic [31:0] got_data);
        int          g;
        bit          found;
        bit          seen;
        bit          exp_err;
        int          waits;
        int          exp_waits;
        logic [31:0] pt;
        logic [63:0] key;
        logic [31:0] exp_data;

        core_lat       = lat;
        core_hang      = hang;
        bus.resp_ready = (hold == 0);
        got_data       = '0;
        #1;

        found = 1'b0;
        g     = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (!found && bus.req_valid[(model_last + k) % NREQ]) begin
                found = 1'b1;
                g     = (model_last + k) % NREQ;
            end
        end
        if (!found) begin
            check({tag, " no requester"}, 1, 0);
            return;
        end
        check({tag, " grant"}, {bus.req_ready, bus.busy}, {4'(1 << g), 1'b0});
        pt         = bus.req_plaintext[g*32 +: 32];
        key        = bus.req_key[g*64 +: 64];
        model_last = g;
        grants.push_back(g);
        exp_err    = hang || (lat + 1 > TIMEOUT);
        exp_waits  = exp_err ? TIMEOUT : lat + 1;
        exp_data   = exp_err ? 32'h0 : simon32(pt, key);

        @(negedge clk);
        check({tag, " issue"}, {bus.core_en, bus.req_ready, bus.busy}, {1'b1, 4'b0, 1'b1});
        check({tag, " operands"}, {bus.core_plaintext, bus.core_key}, {pt, key});

        waits = 0;
        seen  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                seen = 1'b1;
                break;
            end
            waits++;
            check({tag, " wait quiet"}, {bus.core_en, bus.req_ready, bus.busy,
                  bus.core_plaintext, bus.core_key}, {1'b0, 4'b0, 1'b1, pt, key});
        end
        check({tag, " resp seen"}, seen, 1);
        check({tag, " wait cycles"}, waits, exp_waits);
        check({tag, " resp"}, {bus.resp_id, bus.resp_data, bus.resp_err, bus.req_ready},
              {2'(g), exp_data, exp_err, 4'b0});
        got_data = bus.resp_data;

        for (int h = 0; h < int'(hold); h++) begin
            @(negedge clk);
            check({tag, " backpressure"}, {bus.resp_valid, bus.resp_id, bus.resp_data,
                  bus.resp_err, bus.core_en, bus.req_ready},
                  {1'b1, 2'(g), exp_data, exp_err, 1'b0, 4'b0});
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check({tag, " back to idle"}, {bus.resp_valid, bus.busy}, 2'b00);
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_plaintext[i*32 +: 32] = $urandom;
            bus.req_key[i*64 +: 64]       = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst           = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        model_last = NREQ - 1;
    endtask

    // ---------------- Directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        int          order [0:4];
        int          base;

        bus.req_valid     = '0;
        bus.req_plaintext = '0;
        bus.req_key       = '0;
        bus.resp_ready    = 1'b0;
        rst               = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset outputs", {bus.req_ready, bus.resp_valid, bus.busy, bus.core_en,
              bus.resp_id, bus.resp_data, bus.resp_err}, '0);
        check("reset operands", {bus.core_plaintext, bus.core_key}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Known vector from requester 2
        bus.req_plaintext[2*32 +: 32] = 32'h65656877;
        bus.req_key[2*64 +: 64]       = 64'h1918111009080100;
        bus.req_valid                 = 4'b0100;
        run_op(5, 1'b0, 0, "vector", d);
        bus.req_valid = '0;
        check("vector ciphertext", d, 32'hc69be9bb);

        // All requesters held high after reset: rotation 0,1,2,3,0.
        // Each op after the first also starts with a stale done during ISSUE.
        do_reset();
        randomize_operands();
        bus.req_valid = 4'b1111;
        base = grants.size();
        for (int i = 0; i < 5; i++) run_op($urandom_range(1, 9), 1'b0, 0, "rotate", d);
        bus.req_valid = '0;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check("rotation order", grants[base + i], order[i]);

        // Stale done into the next ISSUE; result must be the new vector's.
        randomize_operands();
        bus.req_valid = 4'b0010;
        run_op(2, 1'b0, 0, "stale done", d);
        bus.req_valid = '0;

        // Backpressure for 20 cycles with other requesters waiting
        randomize_operands();
        bus.req_valid = 4'b1011;
        run_op(4, 1'b0, 20, "backpressure", d);
        bus.req_valid = '0;

        // Timeout: core never finishes, then the done-vs-timeout boundary
        randomize_operands();
        bus.req_valid = 4'b0001;
        run_op(3, 1'b1, 0, "timeout", d);
        run_op(TIMEOUT, 1'b0, 2, "late done", d);
        run_op(TIMEOUT - 1, 1'b0, 0, "last cycle done", d);
        bus.req_valid = '0;

        // Reset during WAIT
        randomize_operands();
        bus.req_valid = 4'b0100;
        core_lat      = 8;
        core_hang     = 1'b0;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-wait", {bus.busy, bus.resp_valid, bus.core_en, bus.resp_data},
              {1'b0, 1'b0, 1'b0, 32'h0});
        rst        = 1'b0;
        model_last = NREQ - 1;
        bus.req_valid = 4'b1001;
        run_op(3, 1'b0, 0, "after reset", d);
        check("after reset winner", grants[grants.size() - 1], 0);
        bus.req_valid = '0;

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            randomize_operands();
            bus.req_valid = 4'($urandom_range(1, 15));
            run_op($urandom_range(1, TIMEOUT), ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                   "random", d);
        end
        bus.req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/simon_arbiter.md
Name: simon_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one simon encryption core between NREQ requesters.
- Accepts one request at a time through a valid/ready handshake and holds the plaintext and key stable on the core inputs for the whole operation.
- Pulses the core's en and waits for done, then returns the ciphertext on a single tagged response channel.
- Sits between the requesting engines and the simon core instance. Only one request is in flight at any time.

Parameters:
- N, `N (from utility.vh): word size n; block is 2*N bits.
- M, `M (from utility.vh): key words m; key is N*M bits.
- NREQ, 4: number of requesters, 2..16.
- TIMEOUT, 255: maximum cycles in WAIT before the operation aborts with an error; range 1..65535.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set.
- req_plaintext  in  NREQ*2*N  requester i uses slice [i*2N +: 2N].
- req_key  in  NREQ*N*M  requester i uses slice [i*N*M +: N*M].
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  $clog2(NREQ)  index of the requester that owns the response.
- resp_data  out  2*N  ciphertext.
- resp_err  out  1  set when the operation timed out.
- core_en  out  1  one-cycle start pulse to the core's en.
- core_plaintext  out  2*N  to the core's plaintext input.
- core_key  out  N*M  to the core's key input.
- core_done  in  1  the core's done.
- core_ciphertext  in  2*N  the core's ciphertext.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP (registered).
- Reset (rst=1 at a clock edge):
  - state=IDLE; all outputs 0; held plaintext/key registers 0; wait counter 0.
  - last_grant=NREQ-1, so requester 0 has highest priority after reset.
  - Reset mid-operation aborts everything. Any pending response is discarded and no resp_valid is produced.
- IDLE:
  - Grant is combinational: the first i with req_valid[i]=1, searching from last_grant+1 modulo NREQ.
  - req_ready = one-hot of the grant; all zeros if no req_valid is set.
  - On req_valid[g] & req_ready[g]: latch plaintext/key slice g into hold registers, id<=g, last_grant<=g, go to ISSUE.
- req_ready is 0 in every state other than IDLE.
- ISSUE (exactly 1 cycle):
  - core_en=1.
  - Wait counter cleared.
  - Next state is WAIT.
- WAIT:
  - core_en=0.
  - core_done may still be high from a previous operation during ISSUE; it is ignored there. It is sampled only in WAIT.
  - On core_done=1: resp_data<=core_ciphertext, resp_err<=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with core_done still 0: resp_data<=0, resp_err<=1, go to RESP.
- core_plaintext and core_key are driven from the hold registers continuously, stable from ISSUE through WAIT. The core reads its key every round.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are held stable until resp_ready=1.
  - On resp_valid & resp_ready: go to IDLE. resp_valid is 0 on the next cycle.
  - No new grant is issued in the handshake cycle.
- Latency:
  - Accept edge → ISSUE 1 cycle → WAIT (core latency, NUM_ROUNDS+2 cycles) → RESP.
  - resp_valid rises on the cycle after done is seen.
- Simultaneous requests: exactly one is granted per IDLE visit. Non-granted requesters keep req_valid asserted and are served in rotation. Starvation-free: worst-case wait is NREQ-1 operations.
- A requester may drop req_valid before being granted; it is then simply skipped.
- resp_valid must not depend combinationally on resp_ready.

Test Plan:
- Single request, known vector (N=16, M=4), requester 2:
  - Stimulus: plaintext=32'h65656877, key=64'h1918111009080100.
  - Required: core_en pulses 1 cycle after acceptance; resp_valid with resp_id=2, resp_data=32'hc69be9bb, resp_err=0.
- All 4 req_valid held high after reset, resp_ready tied 1:
  - Grant order is 0,1,2,3,0.
  - req_ready is never multi-hot and is 0 outside IDLE.
- Backpressure:
  - Stimulus: resp_ready=0 for 20 cycles while in RESP.
  - Required: resp_valid, resp_id and resp_data stay constant; core_en stays 0; no requester is granted.
- Timeout:
  - Stimulus: TIMEOUT=10, core_done forced 0.
  - Required: after 10 WAIT cycles, resp_valid=1, resp_err=1, resp_data=0.
- Stale done:
  - Stimulus: after the first operation, core_done is left high into the next ISSUE cycle.
  - Required: the second result is taken only from done seen in WAIT, and equals the second vector's ciphertext.
- Reset mid-WAIT:
  - Stimulus: assert rst for 1 cycle during WAIT.
  - Required: the next cycle has state=IDLE, busy=0, resp_valid=0; then requester 0 wins when 0 and 3 both request.
